multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 OP  input  6  opcode field of the instruction register (IR[31:26]).
REQ-005 mem_ready  input  1  memory completion handshake; 1 = current read/write finishes this cycle.
REQ-006 PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath controls.
REQ-007 ALUSrcB  output  2  00=reg B, 01=constant 4, 10=sign/zero-ext imm, 11=ext imm<<2.
REQ-008 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-009 ALUOp  output  3  111=R-type funct decode, 110=add, 101=or, 001=and, 010=subtract.
REQ-010 state  output  4  current state encoding, for debug/bench observation.

Function
REQ-011 The block SHALL be a Moore FSM; outputs decode from state only, except the mem_ready gating in REQ-013/REQ-016/REQ-017.
REQ-012 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11; encodings 12-15 go to FETCH.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=110 (branch target into ALUOut). Next state by OP: 0x00->EXEC_R; 0x08/0x0D/0x0C->EXEC_I; 0x23/0x2B->MEM_ADDR; 0x04/0x05->BRANCH; 0x02->JUMP; any other value->FETCH, with no write asserted.
REQ-015 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=110. Next is MEM_RD if OP=0x23, else MEM_WR.
REQ-016 MEM_RD: MemRead=1, IorD=1. Hold while mem_ready=0; go to MEM_WB when mem_ready=1.
REQ-017 MEM_WR: MemWrite=1, IorD=1. Hold while mem_ready=0; go to FETCH when mem_ready=1. MemWrite stays high for every waiting cycle.
REQ-018 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next is FETCH.
REQ-019 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next is R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0; next is FETCH.
REQ-020 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=110 for 0x08, 101 for 0x0D, 001 for 0x0C; next is I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0; next is FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCSource=01; PCWriteCondEQ=1 if OP=0x04, PCWriteCondNE=1 if OP=0x05; next is FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next is FETCH.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 OP SHALL be sampled only in DECODE, MEM_ADDR, EXEC_I and BRANCH; OP changes in other states have no effect.
REQ-025 Cycle counts with mem_ready constantly 1: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each mem_ready=0 cycle adds one cycle.

Reset
REQ-026 When reset=1 at a rising edge, the next state SHALL be FETCH regardless of current state or mem_ready.
REQ-027 While reset=1, all control outputs SHALL be forced to 0 combinationally (state still reports the register value), so no write can commit if reset arrives mid-instruction.
REQ-028 In the first cycle after reset deasserts: state=0 and FETCH outputs are active.

Structure
REQ-029 A shared package SHALL hold the state encodings, opcode constants (R_TYPE, ADDI, ORI, ANDI, LW, SW, BEQ, BNE, J) and ALUOp codes.
REQ-030 The design SHALL use one state register plus next-state logic, with output decode in a sub-module mc_output_decode (state, OP, mem_ready, reset -> controls).

Verification
REQ-031 Reset in R_WB: reset=1 -> RegWrite=0 that cycle; state=0 next cycle.
REQ-032 OP=0x00, mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-033 OP=0x23 with mem_ready low 2 cycles in MEM_RD -> sequence 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 in all three state-3 cycles.
REQ-034 OP=0x2B, mem_ready=1 -> sequence 0,1,2,5,0; MemWrite=1 only in state 5.
REQ-035 OP=0x05 -> sequence 0,1,10,0 with PCWriteCondNE=1, ALUOp=010; OP=0x02 -> sequence 0,1,11,0 with PCWrite=1, PCSource=10.
REQ-036 OP=0x3F in DECODE -> next state 0; no RegWrite, MemWrite, PCWrite or PCWriteCond* pulse; FETCH with mem_ready=0 for 3 cycles holds state 0 with IRWrite=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU codes
// and the packed control-word bus handed from the decoder to the top.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } stateT;

    localparam logic [OP_W-1:0] R_TYPE = 6'h00;
    localparam logic [OP_W-1:0] ADDI   = 6'h08;
    localparam logic [OP_W-1:0] ORI    = 6'h0D;
    localparam logic [OP_W-1:0] ANDI   = 6'h0C;
    localparam logic [OP_W-1:0] LW     = 6'h23;
    localparam logic [OP_W-1:0] SW     = 6'h2B;
    localparam logic [OP_W-1:0] BEQ    = 6'h04;
    localparam logic [OP_W-1:0] BNE    = 6'h05;
    localparam logic [OP_W-1:0] J      = 6'h02;

    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b111;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b010;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic                pcWrite;
        logic                pcWriteCondEq;
        logic                pcWriteCondNe;
        logic                iOrD;
        logic                memRead;
        logic                memWrite;
        logic                irWrite;
        logic                memToReg;
        logic                regDst;
        logic                regWrite;
        logic                aluSrcA;
        logic [SEL_W-1:0]    aluSrcB;
        logic [SEL_W-1:0]    pcSource;
        logic [ALUOP_W-1:0]  aluOp;
    } ctrlT;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller; mem_ready only gates the
// fetch-commit strobes and reset blanks every control.
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  stateT             state,
    input  logic [OP_W-1:0]   OP,
    input  logic              mem_ready,
    input  logic              reset,
    output ctrlT              ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = mem_ready;
                ctrl.pcWrite  = mem_ready;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iOrD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEM_WR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iOrD     = 1'b1;
            end
            EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALU_RTYPE;
            end
            R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            EXEC_I: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                case (OP)
                    ORI:     ctrl.aluOp = ALU_OR;
                    ANDI:    ctrl.aluOp = ALU_AND;
                    default: ctrl.aluOp = ALU_ADD;
                endcase
            end
            I_WB: begin
                ctrl.regWrite = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA       = 1'b1;
                ctrl.aluSrcB       = SRCB_REG;
                ctrl.aluOp         = ALU_SUB;
                ctrl.pcSource      = PCSRC_ALUOUT;
                ctrl.pcWriteCondEq = (OP == BEQ);
                ctrl.pcWriteCondNe = (OP == BNE);
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        // Blank everything under reset so an interrupted instruction commits nothing
        if (reset) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: one state register, next-state logic here,
// control decode in mc_output_decode.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     OP,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCondEQ,
    output logic                PCWriteCondNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [STATE_W-1:0]  state
);

    stateT stateReg;
    stateT nextState;
    ctrlT  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= nextState;
        end
    end

    // OP is only consulted in the states that branch on it
    always_comb begin
        nextState = FETCH;
        case (stateReg)
            FETCH:    nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (OP)
                    R_TYPE:           nextState = EXEC_R;
                    ADDI, ORI, ANDI:  nextState = EXEC_I;
                    LW, SW:           nextState = MEM_ADDR;
                    BEQ, BNE:         nextState = BRANCH;
                    J:                nextState = JUMP;
                    default:          nextState = FETCH;
                endcase
            end
            MEM_ADDR: nextState = (OP == LW) ? MEM_RD : MEM_WR;
            MEM_RD:   nextState = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
            EXEC_R:   nextState = R_WB;
            EXEC_I:   nextState = I_WB;
            default:  nextState = FETCH;
        endcase
    end

    mc_output_decode uDecode (
        .state     (stateReg),
        .OP        (OP),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    assign PCWrite       = ctrl.pcWrite;
    assign PCWriteCondEQ = ctrl.pcWriteCondEq;
    assign PCWriteCondNE = ctrl.pcWriteCondNe;
    assign IorD          = ctrl.iOrD;
    assign MemRead       = ctrl.memRead;
    assign MemWrite      = ctrl.memWrite;
    assign IRWrite       = ctrl.irWrite;
    assign MemtoReg      = ctrl.memToReg;
    assign RegDst        = ctrl.regDst;
    assign RegWrite      = ctrl.regWrite;
    assign ALUSrcA       = ctrl.aluSrcA;
    assign ALUSrcB       = ctrl.aluSrcB;
    assign PCSource      = ctrl.pcSource;
    assign ALUOp         = ctrl.aluOp;
    assign state         = STATE_W'(stateReg);

endmodule
